// File: rtl/match_sequencer_pkg.sv
// Shared definitions for the game-flow controller and the win-screen renderer:
// phase encodings, winner encoding, background colour and the blink-off pixel rule.
package match_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        PLAY  = 2'd2,
        WIN   = 2'd3
    } state_t;

    localparam logic PLAYER1 = 1'b1;
    localparam logic PLAYER2 = 1'b0;

    localparam logic [23:0] BACKGROUND_COLOUR = 24'h00_64_00;

    // Text pixels vanish into the background; black and background pixels are kept.
    function automatic logic [23:0] blink_off_pixel(input logic [23:0] px, input logic [23:0] bg);
        logic [23:0] result;
        if ((px != bg) && (px != 24'h00_00_00)) begin
            result = bg;
        end else begin
            result = px;
        end
        return result;
    endfunction

endpackage

// File: rtl/match_sequencer_frame_timer.sv
// Frame tick from the vsync falling edge plus a clearable frame counter that
// wraps at LAST and flags the tick on which it wraps.
module frame_timer #(
    parameter int CNT_W = 10,
    parameter int LAST  = 599
) (
    input  logic clock,
    input  logic reset,
    input  logic vsync,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic wrap
);

    logic             vsync_prev_r;
    logic [CNT_W-1:0] count_r;

    // Remember the previous vsync level for the falling-edge detector.
    always_ff @(posedge clock) begin
        if (reset) begin
            vsync_prev_r <= 1'b1;
        end else begin
            vsync_prev_r <= vsync;
        end
    end

    assign tick = vsync_prev_r & ~vsync;
    assign wrap = enable & tick & (count_r == CNT_W'(LAST));

    // Frame counter: advances once per tick while enabled, never passes LAST.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && tick) begin
            if (count_r == CNT_W'(LAST)) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/match_sequencer.sv
// Game-flow controller: title / clear / play / win sequencing, winner latch,
// and the final pixel mux with a frame-counted blinking win screen.
module match_sequencer
    import match_sequencer_pkg::*;
#(
    parameter int          WIN_FRAMES   = 600,
    parameter int          BLINK_FRAMES = 30,
    parameter int          CNT_W        = 10,
    parameter logic [23:0] BACKGROUND   = BACKGROUND_COLOUR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vsync,
    input  logic        start,
    input  logic        p1_win,
    input  logic        p2_win,
    input  logic [23:0] game_pixel,
    input  logic [23:0] win_pixel,
    output logic        win_sel,
    output logic        game_enable,
    output logic        game_clear,
    output logic [1:0]  phase,
    output logic [23:0] pixel
);

    state_t      state_r;
    state_t      next_state_s;
    logic        start_prev_r;
    logic        blink_r;
    logic        win_sel_r;
    logic        game_enable_r;
    logic        game_clear_r;
    logic [23:0] pixel_r;
    logic [23:0] pixel_next_s;
    logic        press_s;
    logic        in_win_s;
    logic        frame_tick_s;
    logic        hold_done_s;
    logic        blink_wrap_s;
    logic        unused_blink_tick_s;

    assign press_s  = start & ~start_prev_r;
    assign in_win_s = (state_r == WIN);

    // Both counters sit at zero outside WIN, so entering WIN always starts a fresh count.
    frame_timer #(.CNT_W(CNT_W), .LAST(WIN_FRAMES - 1)) u_hold_timer (
        .clock  (clock),
        .reset  (reset),
        .vsync  (vsync),
        .clear  (~in_win_s),
        .enable (in_win_s),
        .tick   (frame_tick_s),
        .wrap   (hold_done_s)
    );

    frame_timer #(.CNT_W(CNT_W), .LAST(BLINK_FRAMES - 1)) u_blink_timer (
        .clock  (clock),
        .reset  (reset),
        .vsync  (vsync),
        .clear  (~in_win_s),
        .enable (in_win_s),
        .tick   (unused_blink_tick_s),
        .wrap   (blink_wrap_s)
    );

    // Next-state selection; a rematch press beats a same-cycle win timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (press_s) next_state_s = CLEAR;
                else         next_state_s = IDLE;
            end
            CLEAR: begin
                if (frame_tick_s) next_state_s = PLAY;
                else              next_state_s = CLEAR;
            end
            PLAY: begin
                if (p1_win || p2_win) next_state_s = WIN;
                else                  next_state_s = PLAY;
            end
            WIN: begin
                if (press_s)          next_state_s = CLEAR;
                else if (hold_done_s) next_state_s = IDLE;
                else                  next_state_s = WIN;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Pixel source follows the registered state, so a transition shows one cycle later.
    always_comb begin
        if (state_r == WIN) begin
            if (blink_r) pixel_next_s = win_pixel;
            else         pixel_next_s = blink_off_pixel(win_pixel, BACKGROUND);
        end else begin
            pixel_next_s = game_pixel;
        end
    end

    // State register with outputs registered from the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            start_prev_r  <= 1'b0;
            blink_r       <= 1'b1;
            win_sel_r     <= PLAYER2;
            game_enable_r <= 1'b0;
            game_clear_r  <= 1'b0;
            pixel_r       <= 24'h00_00_00;
        end else begin
            state_r       <= next_state_s;
            start_prev_r  <= start;
            game_enable_r <= (next_state_s == PLAY);
            game_clear_r  <= (next_state_s == CLEAR);
            pixel_r       <= pixel_next_s;
            if ((state_r == PLAY) && (next_state_s == WIN)) begin
                win_sel_r <= p1_win ? PLAYER1 : PLAYER2;
            end
            if (!in_win_s) begin
                blink_r <= 1'b1;
            end else if (blink_wrap_s) begin
                blink_r <= ~blink_r;
            end
        end
    end

    assign win_sel     = win_sel_r;
    assign game_enable = game_enable_r;
    assign game_clear  = game_clear_r;
    assign phase       = state_r;
    assign pixel       = pixel_r;

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer: directed scenarios plus randomized
// traffic compared against a frame-counting reference model.
module tb_match_sequencer;

    localparam int          WF = 4;
    localparam int          BF = 2;
    localparam int          VP = 20;
    localparam logic [23:0] BG = 24'h006400;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b1;
    logic        start = 1'b0;
    logic        p1_win = 1'b0;
    logic        p2_win = 1'b0;
    logic [23:0] game_pixel = 24'h0;
    logic [23:0] win_pixel = 24'h0;
    logic        win_sel;
    logic        game_enable;
    logic        game_clear;
    logic [1:0]  phase;
    logic [23:0] pixel;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: phase number, ticks seen since entering WIN, winner, pixel.
    logic [1:0]  m_phase = 2'd0;
    logic        m_win_sel = 1'b0;
    logic        m_start_prev = 1'b0;
    logic        m_vsync_prev = 1'b1;
    int          m_ticks = 0;
    logic [23:0] m_pixel = 24'h0;

    match_sequencer #(
        .WIN_FRAMES(WF), .BLINK_FRAMES(BF), .CNT_W(10), .BACKGROUND(BG)
    ) dut (
        .clock(clock), .reset(reset), .vsync(vsync), .start(start),
        .p1_win(p1_win), .p2_win(p2_win), .game_pixel(game_pixel), .win_pixel(win_pixel),
        .win_sel(win_sel), .game_enable(game_enable), .game_clear(game_clear),
        .phase(phase), .pixel(pixel)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] model_pixel();
        logic [23:0] px;
        if (m_phase == 2'd3) begin
            if (((m_ticks / BF) % 2) == 0)               px = win_pixel;
            else if (win_pixel == BG || win_pixel == 24'h0) px = win_pixel;
            else                                          px = BG;
        end else begin
            px = game_pixel;
        end
        return px;
    endfunction

    task automatic model_update();
        logic tk;
        logic pr;
        if (reset) begin
            m_phase = 2'd0; m_win_sel = 1'b0; m_start_prev = 1'b0;
            m_vsync_prev = 1'b1; m_ticks = 0; m_pixel = 24'h0;
        end else begin
            tk = m_vsync_prev && !vsync;
            pr = start && !m_start_prev;
            m_pixel = model_pixel();
            case (m_phase)
                2'd0: if (pr) m_phase = 2'd1;
                2'd1: if (tk) m_phase = 2'd2;
                2'd2: if (p1_win || p2_win) begin
                    m_phase = 2'd3; m_win_sel = p1_win; m_ticks = 0;
                end
                default: begin
                    if (pr) m_phase = 2'd1;
                    else if (tk) begin
                        m_ticks++;
                        if (m_ticks == WF) m_phase = 2'd0;
                    end
                end
            endcase
            m_vsync_prev = vsync;
            m_start_prev = start;
        end
    endtask

    // vsync is low for the first two clocks of every VP-clock frame.
    task automatic step();
        vsync = ((cyc % VP) < 2) ? 1'b0 : 1'b1;
        @(posedge clock);
        model_update();
        #1;
        cyc++;
    endtask

    task automatic go_play();
        int n = 0;
        start = 1'b0; step();
        start = 1'b1; step();
        start = 1'b0;
        while (m_phase != 2'd2 && n < 3 * VP) begin step(); n++; end
        checks++;
        if (phase !== 2'd2) begin errors++; $display("FAIL go_play phase: got %0d want 2", phase); end
    endtask

    task automatic test_reset();
        reset = 1'b1; game_pixel = 24'hABCDEF; step(); step();
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset phase: got %0d want 0", phase); end
        checks++; if (pixel !== 24'h0) begin errors++; $display("FAIL reset pixel: got %h want 000000", pixel); end
        checks++; if (game_enable !== 1'b0) begin errors++; $display("FAIL reset enable: got %b want 0", game_enable); end
        checks++; if (game_clear !== 1'b0) begin errors++; $display("FAIL reset clear: got %b want 0", game_clear); end
        checks++; if (win_sel !== 1'b0) begin errors++; $display("FAIL reset win_sel: got %b want 0", win_sel); end
        reset = 1'b0;
    endtask

    task automatic test_start_clear();
        int n = 0;
        step(); step();
        start = 1'b1; step(); start = 1'b0;
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL clear entry phase: got %0d want 1", phase); end
        checks++; if (game_clear !== 1'b1) begin errors++; $display("FAIL clear entry game_clear: got %b want 1", game_clear); end
        while (phase == 2'd1 && n < 2 * VP) begin
            step(); n++;
            if (phase == 2'd1) begin
                checks++; if (game_clear !== 1'b1) begin errors++; $display("FAIL clear hold game_clear: got %b want 1", game_clear); end
            end
        end
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL clear exit phase: got %0d want 2", phase); end
        checks++; if (((cyc - 1) % VP) != 0) begin errors++; $display("FAIL clear exit frame: cycle %0d not on a vsync fall", cyc - 1); end
        checks++; if (game_enable !== 1'b1) begin errors++; $display("FAIL play enable: got %b want 1", game_enable); end
        checks++; if (game_clear !== 1'b0) begin errors++; $display("FAIL play clear: got %b want 0", game_clear); end
    endtask

    task automatic test_p2_win();
        int n = 0;
        int n_prev;
        int k = 0;
        while ((cyc % VP) != 5 && k < VP) begin step(); k++; end
        game_pixel = 24'h111111; win_pixel = 24'hFFFFFF;
        p2_win = 1'b1; step(); p2_win = 1'b0;
        checks++; if (phase !== 2'd3) begin errors++; $display("FAIL p2 phase: got %0d want 3", phase); end
        checks++; if (win_sel !== 1'b0) begin errors++; $display("FAIL p2 win_sel: got %b want 0", win_sel); end
        checks++; if (game_enable !== 1'b0) begin errors++; $display("FAIL p2 enable: got %b want 0", game_enable); end
        checks++; if (pixel !== 24'h111111) begin errors++; $display("FAIL p2 entry pixel: got %h want 111111", pixel); end
        k = 0;
        while (phase == 2'd3 && k < 10 * VP) begin
            n_prev = n;
            if ((cyc % VP) == 0) n++;
            step(); k++;
            checks++;
            if (pixel !== ((n_prev < BF) ? 24'hFFFFFF : BG)) begin
                errors++; $display("FAIL blink pixel after %0d ticks: got %h want %h", n_prev, pixel, (n_prev < BF) ? 24'hFFFFFF : BG);
            end
        end
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL win timeout phase: got %0d want 0", phase); end
        checks++; if (n != WF) begin errors++; $display("FAIL win timeout ticks: got %0d want %0d", n, WF); end
    endtask

    task automatic test_both_win();
        int k = 0;
        go_play();
        win_pixel = BG;
        p1_win = 1'b1; p2_win = 1'b1; step(); p1_win = 1'b0; p2_win = 1'b0;
        checks++; if (phase !== 2'd3) begin errors++; $display("FAIL both phase: got %0d want 3", phase); end
        checks++; if (win_sel !== 1'b1) begin errors++; $display("FAIL both win_sel: got %b want 1", win_sel); end
        while (phase == 2'd3 && k < 10 * VP) begin
            step(); k++;
            checks++; if (pixel !== BG) begin errors++; $display("FAIL bg pixel: got %h want %h", pixel, BG); end
        end
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL both timeout phase: got %0d want 0", phase); end
        checks++; if (win_sel !== 1'b1) begin errors++; $display("FAIL win_sel hold idle: got %b want 1", win_sel); end
    endtask

    task automatic test_rematch();
        int k = 0;
        go_play();
        p1_win = 1'b1; step(); p1_win = 1'b0;
        while (!(m_phase == 2'd3 && m_ticks == WF - 1 && (cyc % VP) == 0) && k < 10 * VP) begin step(); k++; end
        checks++; if (m_phase != 2'd3) begin errors++; $display("FAIL rematch setup: model phase %0d want 3", m_phase); end
        start = 1'b1; step(); start = 1'b0;
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL rematch phase: got %0d want 1", phase); end
        checks++; if (game_clear !== 1'b1) begin errors++; $display("FAIL rematch clear: got %b want 1", game_clear); end
    endtask

    task automatic test_start_held();
        int entries = 0;
        logic [1:0] prev;
        reset = 1'b1; step(); reset = 1'b0; step();
        prev = phase;
        start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (phase == 2'd1 && prev != 2'd1) entries++;
            prev = phase;
        end
        start = 1'b0;
        checks++; if (entries != 1) begin errors++; $display("FAIL held start entries: got %0d want 1", entries); end
    endtask

    task automatic test_reset_mid_win();
        go_play();
        p1_win = 1'b1; step(); p1_win = 1'b0;
        for (int i = 0; i < 25; i++) step();
        checks++; if (phase !== 2'd3) begin errors++; $display("FAIL midwin setup phase: got %0d want 3", phase); end
        reset = 1'b1; step();
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL midwin reset phase: got %0d want 0", phase); end
        checks++; if (pixel !== 24'h0) begin errors++; $display("FAIL midwin reset pixel: got %h want 000000", pixel); end
        checks++; if (game_enable !== 1'b0) begin errors++; $display("FAIL midwin reset enable: got %b want 0", game_enable); end
        checks++; if (win_sel !== 1'b0) begin errors++; $display("FAIL midwin reset win_sel: got %b want 0", win_sel); end
        game_pixel = 24'h123456; reset = 1'b0; step();
        checks++; if (pixel !== 24'h123456) begin errors++; $display("FAIL idle pixel: got %h want 123456", pixel); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) start = ~start;
            p1_win = ($urandom_range(0, 15) == 0);
            p2_win = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 999) == 0);
            game_pixel = 24'($urandom);
            win_pixel = ($urandom_range(0, 3) == 0) ? BG : (24'($urandom) | 24'h000001);
            step();
            checks++; if (phase !== m_phase) begin errors++; $display("FAIL random phase @%0d: got %0d want %0d", cyc, phase, m_phase); end
            checks++; if (win_sel !== m_win_sel) begin errors++; $display("FAIL random win_sel @%0d: got %b want %b", cyc, win_sel, m_win_sel); end
            checks++; if (game_enable !== (m_phase == 2'd2)) begin errors++; $display("FAIL random enable @%0d: got %b want %b", cyc, game_enable, m_phase == 2'd2); end
            checks++; if (game_clear !== (m_phase == 2'd1)) begin errors++; $display("FAIL random clear @%0d: got %b want %b", cyc, game_clear, m_phase == 2'd1); end
            checks++; if (pixel !== m_pixel) begin errors++; $display("FAIL random pixel @%0d: got %h want %h", cyc, pixel, m_pixel); end
        end
        reset = 1'b0; start = 1'b0; p1_win = 1'b0; p2_win = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_clear();
        test_p2_win();
        test_both_win();
        test_rematch();
        test_start_held();
        test_reset_mid_win();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
- Top-level game-flow controller for the video path.
- Sequences the game through title, clear, play and win phases, and latches which player won.
- Gates the game logic with enable and clear strobes.
- Muxes the final 24-bit pixel between the live game renderer and the win-screen renderer, blinking the win text on a frame-counted schedule.
- Sits between the game/physics logic, the two pixel renderers and the VGA output stage.

Parameters:
- WIN_FRAMES, 600, frames the win screen is held before returning to IDLE (10 s at 60 Hz).
- BLINK_FRAMES, 30, frames per blink half-period of the win text.
- CNT_W, 10, width of the frame counters; must hold WIN_FRAMES.
- BACKGROUND, 24'h00_64_00, win-screen background colour; also the blank colour for text during the blink-off phase.

Ports:
- clock  in  1  pixel clock
- reset  in  1  synchronous, active-high
- vsync  in  1  active-low vertical sync from the VGA timing generator
- start  in  1  debounced start button, level
- p1_win  in  1  one-cycle pulse from game logic: player 1 has won
- p2_win  in  1  one-cycle pulse from game logic: player 2 has won
- game_pixel  in  24  pixel from the live game renderer
- win_pixel  in  24  pixel from the win-screen renderer
- win_sel  out  1  drives the win-screen renderer select; 1 = player 1 won, 0 = player 2 won
- game_enable  out  1  high only in PLAY; game logic advances only while high
- game_clear  out  1  high for the whole CLEAR state; game logic resets its positions and scores
- phase  out  2  current state encoding, for LEDs/debug
- pixel  out  24  registered output pixel

Behaviour:
- Reset (synchronous, active-high) values:
  - state = IDLE, win_sel = 0, game_enable = 0, game_clear = 0, pixel = 0.
  - Frame counter = 0, blink = 1, start_prev = 0, vsync_prev = 1.
- Reset has priority over every other input in every state, including mid-PLAY and mid-WIN.
- Frame tick: one-cycle internal pulse on the vsync falling edge (vsync_prev = 1 and vsync = 0).
- Start press: one-cycle pulse on the start rising edge (start = 1 and start_prev = 0). Holding start produces exactly one press.
- States: IDLE = 2'd0, CLEAR = 2'd1, PLAY = 2'd2, WIN = 2'd3.
- IDLE:
  - Outputs: game_enable = 0, pixel source = game_pixel (a frozen field).
  - Start press moves to CLEAR.
- CLEAR:
  - game_clear = 1.
  - Stays until the next frame tick, then moves to PLAY, so play always begins on a frame boundary.
  - Minimum CLEAR duration is 1 cycle: a tick coinciding with entry still exits on that tick.
- PLAY:
  - game_enable = 1, pixel source = game_pixel.
  - p1_win moves to WIN with win_sel = 1.
  - p2_win (without p1_win) moves to WIN with win_sel = 0.
  - Both pulses in the same cycle: player 1 wins (win_sel = 1).
  - A start press in PLAY is ignored.
- WIN:
  - On entry: frame counter = 0, blink counter = 0, blink = 1.
  - game_enable = 0; win_sel holds its value.
  - Each frame tick increments the frame counter and the blink counter.
  - When the blink counter reaches BLINK_FRAMES - 1 on a tick, it wraps to 0 and blink toggles.
  - When the frame counter reaches WIN_FRAMES - 1 on a tick, the state moves to IDLE.
  - A start press moves to CLEAR immediately (rematch), taking priority over a same-cycle timeout.
  - Pixel source: if blink = 1, win_pixel; if blink = 0, BACKGROUND whenever win_pixel != BACKGROUND, else win_pixel.
- win_pixel = 0 is passed through unmodified.
- win_sel is updated only on entry to WIN and keeps its value through IDLE/CLEAR/PLAY.
- Pixel latency: 1 clock from game_pixel/win_pixel to pixel. The output stage delays hsync, vsync and blank by 1 clock to match.
- The pixel mux uses the registered state, so a state change takes effect on the pixel in the cycle after the transition.
- Counters never exceed WIN_FRAMES - 1; there is no counter overflow path.
- p1_win and p2_win outside PLAY are ignored.

Decomposition:
- Shared package holds:
  - state encodings IDLE/CLEAR/PLAY/WIN;
  - PLAYER1 = 1'b1, PLAYER2 = 1'b0 (win_sel encoding);
  - BACKGROUND colour constant, shared with the win-screen renderer.
- One sub-module, frame_timer: vsync edge detector producing the frame tick, plus a clearable CNT_W frame counter with a terminal-count output. It is instantiated twice (hold counter and blink counter).

Test Plan (WIN_FRAMES = 4, BLINK_FRAMES = 2; vsync period of 20 clocks):
- Reset, then a start press -> phase = 1 and game_clear = 1 until the next vsync fall; then phase = 2, game_enable = 1, game_clear = 0.
- In PLAY, pulse p2_win -> next cycle phase = 3, win_sel = 0, game_enable = 0. After the 4th vsync fall, phase = 0.
- In PLAY, pulse p1_win and p2_win in the same cycle -> phase = 3, win_sel = 1.
- In WIN, drive win_pixel = 24'hFFFFFF: pixel = FFFFFF for ticks 0–1, then 006400 for ticks 2–3. Drive win_pixel = 006400: pixel = 006400 throughout.
- Start press in WIN on the same cycle as the terminal tick -> phase = 1, not 0. Start held high for 100 cycles in IDLE -> exactly one CLEAR entry.
- Assert reset mid-WIN -> next cycle phase = 0, pixel = 0, game_enable = 0, win_sel = 0. game_pixel = 24'h123456 -> pixel = 123456 one clock later in IDLE.
